// File: rtl/timer_scheduler.sv
// Round-robin scheduler that lends one shared flex counter to a requesting channel
// for one timed interval and pulses done to that channel when the period elapses.
module timer_scheduler #(
   parameter int unsigned NUM_BITS = 4,
   parameter int unsigned NUM_REQ  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*NUM_BITS-1:0]   period,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic                          busy,
   output logic                          cnt_clear,
   output logic                          cnt_enable,
   output logic [NUM_BITS-1:0]           cnt_rollover_val,
   input  logic                          cnt_rollover_flag
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [PTR_W-1:0]     owner_q, owner_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [NUM_BITS-1:0]  rv_q, rv_d;

   logic [NUM_BITS-1:0]  per_arr [NUM_REQ];
   logic                 win_found;
   logic [PTR_W-1:0]     win_idx;
   logic [NUM_REQ-1:0]   win_oh;
   logic [PTR_W-1:0]     ptr_after_owner;
   logic                 owner_req;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign per_arr[g] = period[g*NUM_BITS +: NUM_BITS];
   end

   // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ
   always_comb begin
      int unsigned      cand;
      logic [PTR_W-1:0] cand_idx;
      win_found = 1'b0;
      win_idx   = '0;
      win_oh    = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand     = (32'(ptr_q) + k) % NUM_REQ;
         cand_idx = PTR_W'(cand);
         if (!win_found && req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
      win_oh[win_idx] = 1'b1;
   end

   assign ptr_after_owner = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
   assign owner_req       = |(req & grant_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      grant_d = grant_q;
      done_d  = '0;
      rv_d    = rv_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d = win_oh;
               owner_d = win_idx;
               rv_d    = per_arr[win_idx];
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (!owner_req) begin
               grant_d = '0;
               ptr_d   = ptr_after_owner;
               state_d = IDLE;
            end else if (rv_q == '0) begin
               done_d  = grant_q;
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Abort wins over a simultaneous rollover so no done is issued
            if (!owner_req) begin
               grant_d = '0;
               ptr_d   = ptr_after_owner;
               state_d = IDLE;
            end else if (cnt_rollover_flag) begin
               done_d  = grant_q;
               state_d = DONE;
            end
         end
         DONE: begin
            grant_d = '0;
            ptr_d   = ptr_after_owner;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         grant_q <= '0;
         done_q  <= '0;
         rv_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         rv_q    <= rv_d;
      end
   end

   assign grant            = grant_q;
   assign done             = done_q;
   assign cnt_rollover_val = rv_q;
   assign busy             = (state_q != IDLE);
   assign cnt_clear        = (state_q == LOAD);
   // Stop counting at the period so the counter never overshoots
   assign cnt_enable       = (state_q == RUN) && !cnt_rollover_flag;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with a 4-bit flex counter model on the cnt_* ports.
module tb_timer_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] period;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic        cnt_clear;
   logic        cnt_enable;
   logic [3:0]  cnt_rollover_val;
   logic        cnt_rollover_flag;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;
   logic en_seen;
   int n;
   logic [3:0] exp_g [5];

   timer_scheduler #(.NUM_BITS(4), .NUM_REQ(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .req               (req),
      .period            (period),
      .grant             (grant),
      .done              (done),
      .busy              (busy),
      .cnt_clear         (cnt_clear),
      .cnt_enable        (cnt_enable),
      .cnt_rollover_val  (cnt_rollover_val),
      .cnt_rollover_flag (cnt_rollover_flag)
   );

   always #5 clk = ~clk;

   // Flex counter model: sync clear, count up when enabled, flag at count==rollover
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             count <= '0;
      else if (cnt_clear)  count <= '0;
      else if (cnt_enable) count <= count + 4'd1;
   end
   assign cnt_rollover_flag = (count == cnt_rollover_val);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (cnt_enable) en_seen = 1'b1;
      chk("onehot_grant_done", {30'd0, $onehot0(grant), $onehot0(done)}, 32'h3);
   endtask

   task automatic wait_done(input int max, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (done == 4'd0 && cnt < max);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'h0);
      chk({tag, "_done"},  32'(done), 32'h0);
      chk({tag, "_busy"},  32'(busy), 32'h0);
      chk({tag, "_clear"}, 32'(cnt_clear), 32'h0);
      chk({tag, "_en"},    32'(cnt_enable), 32'h0);
      chk({tag, "_rv"},    32'(cnt_rollover_val), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; req = '0; period = '0; en_seen = 1'b0;
      #2;
      chk_all_zero("reset");
      @(negedge clk) rst = 1'b0;

      // Single channel, period 5
      req = 4'b0001; period = 16'h0005;
      step();
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_rv", 32'(cnt_rollover_val), 32'h5);
      chk("t1_clear", 32'(cnt_clear), 32'h1);
      chk("t1_en_load", 32'(cnt_enable), 32'h0);
      chk("t1_busy", 32'(busy), 32'h1);
      step();
      chk("t1_count0", 32'(count), 32'h0);
      chk("t1_clear_off", 32'(cnt_clear), 32'h0);
      chk("t1_en_run", 32'(cnt_enable), 32'h1);
      repeat (5) step();
      chk("t1_count5", 32'(count), 32'h5);
      chk("t1_en_stop", 32'(cnt_enable), 32'h0);
      chk("t1_no_done_early", 32'(done), 32'h0);
      step();
      chk("t1_done_edge7", 32'(done), 32'h1);
      chk("t1_busy_done", 32'(busy), 32'h1);
      req = 4'b0000;
      step();
      chk("t1_done_pulse", 32'(done), 32'h0);
      chk("t1_busy_idle", 32'(busy), 32'h0);
      chk("t1_grant_idle", 32'(grant), 32'h0);

      // Return the pointer to channel 0
      #2 rst = 1'b1;
      #1 chk_all_zero("rst2");
      @(negedge clk) rst = 1'b0;

      // All channels requesting: round-robin order with wrap
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
      req = 4'b1111; period = 16'h2222;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("t2_grant%0d", i), 32'(grant), 32'(exp_g[i]));
         wait_done(8, n);
         chk($sformatf("t2_done%0d", i), 32'(done), 32'(exp_g[i]));
         chk($sformatf("t2_lat%0d", i), 32'(n), 32'd4);
         step();
         chk($sformatf("t2_gap%0d", i), 32'(grant), 32'h0);
      end
      req = 4'b0000;

      // Zero period: LOAD straight to DONE, counter never enabled
      req = 4'b0100; period = 16'h0000; en_seen = 1'b0;
      step();
      chk("t3_grant", 32'(grant), 32'h4);
      chk("t3_clear", 32'(cnt_clear), 32'h1);
      step();
      chk("t3_done", 32'(done), 32'h4);
      chk("t3_en_never", 32'(en_seen), 32'h0);
      req = 4'b0000;
      step();
      chk("t3_idle", 32'(busy), 32'h0);

      // Abort by dropping req mid-run
      req = 4'b0010; period = 16'h0090;
      step();
      chk("t4_grant", 32'(grant), 32'h2);
      step();
      repeat (4) step();
      chk("t4_count4", 32'(count), 32'h4);
      req = 4'b0000;
      step();
      chk("t4_abort_busy", 32'(busy), 32'h0);
      chk("t4_abort_grant", 32'(grant), 32'h0);
      chk("t4_abort_done", 32'(done), 32'h0);
      req = 4'b0111; period = 16'h0000;
      step();
      chk("t4_ptr2_grant", 32'(grant), 32'h4);
      step();
      chk("t4_ptr2_done", 32'(done), 32'h4);
      req = 4'b0000;
      step();

      // Reset mid-interval, then a full 15-count interval
      req = 4'b0001; period = 16'h000F;
      step();
      chk("t5_grant", 32'(grant), 32'h1);
      chk("t5_rv", 32'(cnt_rollover_val), 32'hF);
      step();
      repeat (8) step();
      chk("t5_count8", 32'(count), 32'h8);
      #2 rst = 1'b1;
      #1 chk_all_zero("t5_async_rst");
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      chk("t5_rst_no_done", 32'(done), 32'h0);
      step();
      chk("t5_regrant", 32'(grant), 32'h1);
      wait_done(40, n);
      chk("t5_done", 32'(done), 32'h1);
      chk("t5_lat", 32'(n), 32'd17);
      req = 4'b0000;
      step();

      // Period input changes after acceptance are ignored
      req = 4'b0001; period = 16'h0005;
      step();
      step();
      step();
      period = 16'h000C;
      step();
      chk("t6_rv_held", 32'(cnt_rollover_val), 32'h5);
      wait_done(20, n);
      chk("t6_done", 32'(done), 32'h1);
      chk("t6_lat", 32'(3 + n), 32'd7);
      req = 4'b0000;
      step();
      chk("t6_idle", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
